ddr3_cmd_responder: RTL and testbench
=====================================

Name: ddr3_cmd_responder

Overview:
Synthesizable DRAM-side responder for the memory controller's DDR3 command interface. It decodes CS/RAS/CAS/WE commands, tracks the open row per bank, and stores write bursts in a small on-chip array. It returns read bursts after CAS latency with a DQS strobe and flags protocol violations. It sits in the bench/loopback build in place of the external DRAM, and drives the DQ/DQS inouts through the top-level tri-state using its `*_oe` outputs.

Parameters:
CL, 5, read latency in clk cycles from READ command to first data beat
CWL, 5, write latency in clk cycles from WRITE command to first data beat
BL, 8, beats per burst, one byte per clk (SDR model); power of 2, ≤ 8
ROW_IDX_BITS, 3, low row bits used to index storage
COL_IDX_BITS, 4, low column bits used to index storage (≥ 3)
REF_MAX, 6400100, maximum clk cycles allowed between REF commands (optional feature only)

Ports:
clk  in  1  200 MHz clock
RESET_SM_button  in  1  asynchronous, active-high reset
reset_dram_n  in  1  DRAM RESET pin; low = synchronous reset of all state except storage
cke  in  1  clock enable; low = command ignored (treated as NOP)
cs_n, ras_n, cas_n, we_n  in  1 each  command bits, active low
addr  in  15  row address (ACT) or column address (RD/WR); addr[10] = auto-precharge / all-banks
ba  in  3  bank address
dq_in  in  8  write data from DQ[7:0]
ldm  in  1  write mask; 1 = beat not stored
dq_out  out  8  read data
dq_oe  out  1  DQ drive enable
dqs_out  out  1  LDQS value (LDQS_n = inverse, handled at top)
dqs_oe  out  1  LDQS drive enable
bank_open  out  8  per-bank open flag
ref_count  out  16  REF commands accepted, wraps at 0xFFFF→0
err_closed  out  1  sticky: READ/WRITE to a closed bank
err_act_open  out  1  sticky: ACT to an already open bank
err_overlap  out  1  sticky: READ/WRITE/ACT/PRE/REF issued while a burst is pending
err_ref_open  out  1  sticky: REF while any bank is open
err_tref  out  1  sticky: refresh interval exceeded (optional feature)

Behaviour:
- Reset (async button, or sync reset_dram_n = 0):
  - All outputs 0; bank_open = 0; ref_count = 0; FSM = S_IDLE.
  - Storage contents are not cleared.
- Command decode when cs_n = 0 and cke = 1, as {ras_n, cas_n, we_n}:
  - 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 ZQ, 111 NOP.
  - cs_n = 1 is deselect.
  - MRS and ZQ are accepted and ignored.
- ACT: latch open_row[ba] = addr; set bank_open[ba]. If the bank is already open, set err_act_open and overwrite the row.
- PRE: addr[10] = 0 clears bank_open[ba]; addr[10] = 1 clears all banks.
- REF: increments ref_count. If any bank is open, set err_ref_open.
- Storage index = {ba, open_row[ba][ROW_IDX_BITS-1:0], col}, one byte per entry.
  - Beat k column = {addr[COL_IDX_BITS-1:3], (addr[2:0] + k) mod 8}: sequential, wraps inside the aligned 8-group.
- FSM states: S_IDLE, S_WR_WAIT, S_WR_BURST, S_RD_WAIT, S_RD_BURST.
- Write path:
  - WRITE in S_IDLE moves to S_WR_WAIT and latches ba, column, addr[10].
  - After CWL cycles, S_WR_BURST samples dq_in for BL cycles (command at cycle t; beats at t+CWL … t+CWL+BL-1).
  - A beat with ldm = 1 leaves its storage byte unchanged.
- Read path:
  - READ in S_IDLE moves to S_RD_WAIT.
  - dqs_oe = 1, dqs_out = 0 at cycle t+CL-1 (preamble).
  - For beats k = 0…BL-1 at cycle t+CL+k: dq_oe = 1, dq_out = storage byte, dqs_out = ~k[0].
  - Both enables drop the cycle after the last beat.
- Auto-precharge: if the latched addr[10] = 1, the bank is closed the cycle after the last beat.
- Burst to a closed bank: set err_closed; no burst, FSM stays in S_IDLE.
- Any non-NOP/MRS/ZQ command outside S_IDLE: set err_overlap; the command is dropped.
- Simultaneous reset and command: reset wins.
- Reset mid-burst: enables drop immediately; remaining beats are discarded.

Optional Feature:
DDR3_RESP_REFRESH_CHECK_EN:
- Defined: 32-bit counter of cycles since the last REF (cleared by reset and by REF). When the counter exceeds REF_MAX, err_tref is set (sticky) and the counter saturates.
- Undefined: no counter; err_tref is tied to 0.

Test Plan:
- ACT ba=5 row=5; WRITE col=1 with dq_in beats 0xA0…0xA7, ldm=0; READ col=1 → dq_out 0xA0…0xA7 at cycles t+5…t+12, dqs_out 1,0,1,0…, preamble at t+4.
- WRITE col=1 with ldm=1 on beats 2 and 5 (data 0x11…0x18); READ → 0x11,0x12,0xA2,0x14,0x15,0xA5,0x17,0x18.
- WRITE col=6 data 0x00…0x07 → bytes stored at columns 6,7,0,1,2,3,4,5; READ col=0 → 0x02,0x03,0x04,0x05,0x06,0x07,0x00,0x01.
- READ ba=3 with no ACT → err_closed = 1, dq_oe stays 0. ACT ba=5 twice → err_act_open = 1. WRITE then READ 2 cycles later → err_overlap = 1, write completes.
- READ with addr[10]=1 → bank_open[5] clears after the last beat. REF with a bank open → err_ref_open = 1, ref_count = 1. Assert RESET_SM_button mid-read → dq_oe = 0 next edge, all flags cleared.
- With DDR3_RESP_REFRESH_CHECK_EN and REF_MAX = 100: REF every 90 cycles → err_tref = 0; gap of 101 cycles → err_tref = 1.

Source files
------------

// File: rtl/ddr3_cmd_responder.sv
// DRAM-side DDR3 command responder: bank/row tracking, burst storage, CL/CWL timed data and DQS.
// Define DDR3_RESP_REFRESH_CHECK_EN to enable the refresh-interval watchdog driving err_tref.
module ddr3_cmd_responder #(
  parameter int CL           = 5,
  parameter int CWL          = 5,
  parameter int BL           = 8,
  parameter int ROW_IDX_BITS = 3,
  parameter int COL_IDX_BITS = 4,
  parameter int REF_MAX      = 6400100
) (
  input  logic        clk,
  input  logic        RESET_SM_button,
  input  logic        reset_dram_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [14:0] addr,
  input  logic [2:0]  ba,
  input  logic [7:0]  dq_in,
  input  logic        ldm,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        dqs_out,
  output logic        dqs_oe,
  output logic [7:0]  bank_open,
  output logic [15:0] ref_count,
  output logic        err_closed,
  output logic        err_act_open,
  output logic        err_overlap,
  output logic        err_ref_open,
  output logic        err_tref
);
  localparam int IDX_W   = 3 + ROW_IDX_BITS + COL_IDX_BITS;
  localparam int LAT_MAX = ((CL > CWL) ? CL : CWL) + BL;
  localparam int CNT_W   = ($clog2(LAT_MAX + 1) < 3) ? 3 : $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_WR_WAIT, S_WR_BURST, S_RD_WAIT, S_RD_BURST} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [2:0]              lat_ba, lat_ba_nxt;
  logic [ROW_IDX_BITS-1:0] lat_row, lat_row_nxt;
  logic [COL_IDX_BITS-1:0] lat_col, lat_col_nxt, beat_col;
  logic                    lat_ap, lat_ap_nxt, ap_pend, ap_pend_nxt;
  logic [ROW_IDX_BITS-1:0] open_row [8];
  logic [ROW_IDX_BITS-1:0] open_row_nxt [8];
  logic [7:0]              bank_live, bank_open_nxt;
  logic [15:0]             ref_count_nxt;
  logic                    err_closed_nxt, err_act_open_nxt, err_overlap_nxt, err_ref_open_nxt;
  logic [7:0]              dq_out_nxt;
  logic                    dq_oe_nxt, dqs_out_nxt, dqs_oe_nxt;
  logic [7:0]              mem [2**IDX_W];
  logic [IDX_W-1:0]        mem_idx;
  logic [7:0]              rd_byte;
  logic                    wr_en;
  logic                    cmd_vld, idle, is_act, is_rd, is_wr, is_pre, is_ref;
  logic                    unused_addr;

  assign cmd_vld     = ~cs_n & cke;
  assign idle        = (state == S_IDLE);
  assign is_act      = cmd_vld & ({ras_n, cas_n, we_n} == 3'b011);
  assign is_rd       = cmd_vld & ({ras_n, cas_n, we_n} == 3'b101);
  assign is_wr       = cmd_vld & ({ras_n, cas_n, we_n} == 3'b100);
  assign is_pre      = cmd_vld & ({ras_n, cas_n, we_n} == 3'b010);
  assign is_ref      = cmd_vld & ({ras_n, cas_n, we_n} == 3'b001);
  assign unused_addr = ^addr;

  // Beat column wraps inside the aligned group of 8 columns.
  always_comb begin
    beat_col      = lat_col;
    beat_col[2:0] = lat_col[2:0] + cnt[2:0];
  end

  assign mem_idx = {lat_ba, lat_row, beat_col};
  assign rd_byte = mem[mem_idx];

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    lat_ba_nxt       = lat_ba;
    lat_row_nxt      = lat_row;
    lat_col_nxt      = lat_col;
    lat_ap_nxt       = lat_ap;
    ap_pend_nxt      = 1'b0;
    open_row_nxt     = open_row;
    ref_count_nxt    = ref_count;
    err_closed_nxt   = err_closed;
    err_act_open_nxt = err_act_open;
    err_overlap_nxt  = err_overlap;
    err_ref_open_nxt = err_ref_open;
    dq_out_nxt       = 8'h00;
    dq_oe_nxt        = 1'b0;
    dqs_out_nxt      = 1'b0;
    dqs_oe_nxt       = 1'b0;
    wr_en            = 1'b0;
    bank_live        = bank_open;
    if (ap_pend) bank_live[lat_ba] = 1'b0;
    bank_open_nxt    = bank_live;

    case (state)
      S_IDLE: begin
        if (is_act) begin
          if (bank_live[ba]) err_act_open_nxt = 1'b1;
          bank_open_nxt[ba] = 1'b1;
          open_row_nxt[ba]  = addr[ROW_IDX_BITS-1:0];
        end else if (is_pre) begin
          if (addr[10]) bank_open_nxt = 8'h00;
          else          bank_open_nxt[ba] = 1'b0;
        end else if (is_ref) begin
          ref_count_nxt = ref_count + 16'd1;
          if (|bank_live) err_ref_open_nxt = 1'b1;
        end else if (is_rd | is_wr) begin
          if (!bank_live[ba]) begin
            err_closed_nxt = 1'b1;
          end else begin
            lat_ba_nxt  = ba;
            lat_row_nxt = open_row[ba];
            lat_col_nxt = addr[COL_IDX_BITS-1:0];
            lat_ap_nxt  = addr[10];
            if (is_wr) begin
              state_nxt = (CWL == 1) ? S_WR_BURST : S_WR_WAIT;
              cnt_nxt   = (CWL == 1) ? '0 : CNT_W'(1);
            end else begin
              state_nxt  = (CL == 1) ? S_RD_BURST : S_RD_WAIT;
              cnt_nxt    = (CL == 1) ? '0 : CNT_W'(1);
              dqs_oe_nxt = (CL == 1);
            end
          end
        end
      end
      S_WR_WAIT: begin
        if (cnt == CNT_W'(CWL - 1)) begin
          state_nxt = S_WR_BURST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WR_BURST: begin
        wr_en = ~ldm;
        if (cnt == CNT_W'(BL - 1)) begin
          state_nxt   = S_IDLE;
          ap_pend_nxt = lat_ap;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RD_WAIT: begin
        if (cnt == CNT_W'(CL - 1)) begin
          state_nxt  = S_RD_BURST;
          cnt_nxt    = '0;
          dqs_oe_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RD_BURST: begin
        dq_oe_nxt   = 1'b1;
        dq_out_nxt  = rd_byte;
        dqs_oe_nxt  = 1'b1;
        dqs_out_nxt = ~cnt[0];
        if (cnt == CNT_W'(BL - 1)) begin
          state_nxt   = S_IDLE;
          ap_pend_nxt = lat_ap;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (!idle && (is_act | is_rd | is_wr | is_pre | is_ref)) err_overlap_nxt = 1'b1;

    // DRAM reset pin overrides any command in the same cycle; storage is untouched.
    if (!reset_dram_n) begin
      state_nxt        = S_IDLE;
      cnt_nxt          = '0;
      lat_ba_nxt       = '0;
      lat_row_nxt      = '0;
      lat_col_nxt      = '0;
      lat_ap_nxt       = 1'b0;
      ap_pend_nxt      = 1'b0;
      open_row_nxt     = '{default: '0};
      bank_open_nxt    = 8'h00;
      ref_count_nxt    = 16'h0000;
      err_closed_nxt   = 1'b0;
      err_act_open_nxt = 1'b0;
      err_overlap_nxt  = 1'b0;
      err_ref_open_nxt = 1'b0;
      dq_out_nxt       = 8'h00;
      dq_oe_nxt        = 1'b0;
      dqs_out_nxt      = 1'b0;
      dqs_oe_nxt       = 1'b0;
      wr_en            = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET_SM_button) begin
    if (RESET_SM_button) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lat_ba       <= '0;
      lat_row      <= '0;
      lat_col      <= '0;
      lat_ap       <= 1'b0;
      ap_pend      <= 1'b0;
      open_row     <= '{default: '0};
      bank_open    <= 8'h00;
      ref_count    <= 16'h0000;
      err_closed   <= 1'b0;
      err_act_open <= 1'b0;
      err_overlap  <= 1'b0;
      err_ref_open <= 1'b0;
      dq_out       <= 8'h00;
      dq_oe        <= 1'b0;
      dqs_out      <= 1'b0;
      dqs_oe       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lat_ba       <= lat_ba_nxt;
      lat_row      <= lat_row_nxt;
      lat_col      <= lat_col_nxt;
      lat_ap       <= lat_ap_nxt;
      ap_pend      <= ap_pend_nxt;
      open_row     <= open_row_nxt;
      bank_open    <= bank_open_nxt;
      ref_count    <= ref_count_nxt;
      err_closed   <= err_closed_nxt;
      err_act_open <= err_act_open_nxt;
      err_overlap  <= err_overlap_nxt;
      err_ref_open <= err_ref_open_nxt;
      dq_out       <= dq_out_nxt;
      dq_oe        <= dq_oe_nxt;
      dqs_out      <= dqs_out_nxt;
      dqs_oe       <= dqs_oe_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !RESET_SM_button) mem[mem_idx] <= dq_in;
  end

`ifdef DDR3_RESP_REFRESH_CHECK_EN
  logic [31:0] ref_gap;

  // Counter holds once past the limit; only an accepted REF restarts it.
  always_ff @(posedge clk or posedge RESET_SM_button) begin
    if (RESET_SM_button) begin
      ref_gap  <= 32'd0;
      err_tref <= 1'b0;
    end else if (!reset_dram_n) begin
      ref_gap  <= 32'd0;
      err_tref <= 1'b0;
    end else if (is_ref && idle) begin
      ref_gap <= 32'd0;
    end else if (ref_gap > 32'(REF_MAX)) begin
      err_tref <= 1'b1;
    end else begin
      ref_gap <= ref_gap + 32'd1;
    end
  end
`else
  logic [31:0] unused_ref_max;
  assign unused_ref_max = 32'(REF_MAX);
  assign err_tref       = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: burst timing, masking, wrap, error flags and resets.
module tb_ddr3_cmd_responder;
  localparam int CL  = 5;
  localparam int CWL = 5;
  localparam int BL  = 8;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        RESET_SM_button, reset_dram_n, cke, cs_n, ras_n, cas_n, we_n;
  logic [14:0] addr;
  logic [2:0]  ba;
  logic [7:0]  dq_in;
  logic        ldm;
  logic [7:0]  dq_out;
  logic        dq_oe, dqs_out, dqs_oe;
  logic [7:0]  bank_open;
  logic [15:0] ref_count;
  logic        err_closed, err_act_open, err_overlap, err_ref_open, err_tref;
  int          total = 0;
  int          bad = 0;

  ddr3_cmd_responder #(
    .CL(CL), .CWL(CWL), .BL(BL), .ROW_IDX_BITS(3), .COL_IDX_BITS(4), .REF_MAX(100)
  ) dut (
    .clk(clk), .RESET_SM_button(RESET_SM_button), .reset_dram_n(reset_dram_n), .cke(cke),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr), .ba(ba),
    .dq_in(dq_in), .ldm(ldm), .dq_out(dq_out), .dq_oe(dq_oe), .dqs_out(dqs_out),
    .dqs_oe(dqs_oe), .bank_open(bank_open), .ref_count(ref_count), .err_closed(err_closed),
    .err_act_open(err_act_open), .err_overlap(err_overlap), .err_ref_open(err_ref_open),
    .err_tref(err_tref)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    tick();
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic wr_burst(input logic [2:0] b, input logic [14:0] a, input logic [63:0] data,
                          input logic [7:0] mask);
    issue(C_WR, b, a);
    repeat (CWL - 1) tick();
    for (int k = 0; k < BL; k++) begin
      dq_in = data[63-8*k -: 8];
      ldm   = mask[k];
      tick();
    end
    dq_in = 8'h00;
    ldm   = 1'b0;
  endtask

  task automatic rd_burst(input string tag, input logic [2:0] b, input logic [14:0] a,
                          input logic [63:0] want);
    logic s;
    issue(C_RD, b, a);
    repeat (CL - 1) tick();
    check({tag, "_pre"}, 32'({dqs_oe, dqs_out, dq_oe}), 32'(3'b100));
    for (int k = 0; k < BL; k++) begin
      tick();
      s = (k % 2 == 0) ? 1'b1 : 1'b0;
      check({tag, "_dq"}, 32'(dq_out), 32'(want[63-8*k -: 8]));
      check({tag, "_strb"}, 32'({dq_oe, dqs_oe, dqs_out}), 32'({2'b11, s}));
    end
    tick();
    check({tag, "_off"}, 32'({dq_oe, dqs_oe}), 32'(0));
  endtask

  initial begin
    RESET_SM_button = 1'b1; reset_dram_n = 1'b1; cke = 1'b1; cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP; addr = '0; ba = '0; dq_in = '0; ldm = 1'b0;
    @(negedge clk);
    tick();
    check("rst_out", 32'({dq_oe, dqs_oe, dqs_out, dq_out}), 32'(0));
    check("rst_bank", 32'(bank_open), 32'(0));
    check("rst_refc", 32'(ref_count), 32'(0));
    check("rst_err", 32'({err_closed, err_act_open, err_overlap, err_ref_open, err_tref}), 32'(0));
    RESET_SM_button = 1'b0;
    tick();

    issue(C_ACT, 3'd5, 15'd5);
    check("act_bank", 32'(bank_open), 32'h20);
    wr_burst(3'd5, 15'd1, 64'hA0A1A2A3A4A5A6A7, 8'h00);
    rd_burst("rd_basic", 3'd5, 15'd1, 64'hA0A1A2A3A4A5A6A7);
    wr_burst(3'd5, 15'd1, 64'h1112131415161718, 8'b0010_0100);
    rd_burst("rd_mask", 3'd5, 15'd1, 64'h1112A21415A51718);
    wr_burst(3'd5, 15'd6, 64'h0001020304050607, 8'h00);
    rd_burst("rd_wrap", 3'd5, 15'd0, 64'h0203040506070001);

    issue(C_RD, 3'd3, 15'd0);
    check("err_closed", 32'(err_closed), 32'(1));
    repeat (CL) tick();
    check("closed_quiet", 32'({dq_oe, dqs_oe}), 32'(0));

    issue(C_ACT, 3'd5, 15'd5);
    check("err_act_open", 32'(err_act_open), 32'(1));
    check("act_again_bank", 32'(bank_open), 32'h20);

    issue(C_WR, 3'd5, 15'd8);
    check("ovl_clean", 32'(err_overlap), 32'(0));
    tick();
    issue(C_RD, 3'd5, 15'd8);
    check("err_overlap", 32'(err_overlap), 32'(1));
    repeat (CWL - 3) tick();
    for (int k = 0; k < BL; k++) begin
      dq_in = 8'h30 + 8'(k);
      tick();
    end
    dq_in = 8'h00;
    check("ovl_rd_dropped", 32'(dq_oe), 32'(0));
    rd_burst("rd_ovl", 3'd5, 15'd8, 64'h3031323334353637);
    check("no_ap_bank", 32'(bank_open), 32'h20);

    rd_burst("rd_ap", 3'd5, 15'h400, 64'h0203040506070001);
    check("ap_close", 32'(bank_open), 32'h00);

    issue(C_ACT, 3'd2, 15'd1);
    issue(C_REF, 3'd0, 15'd0);
    check("err_ref_open", 32'(err_ref_open), 32'(1));
    check("ref_count1", 32'(ref_count), 32'(1));

    issue(C_RD, 3'd2, 15'd0);
    repeat (CL) tick();
    check("mid_rd_on", 32'(dq_oe), 32'(1));
    RESET_SM_button = 1'b1;
    tick();
    check("mid_rst_oe", 32'({dq_oe, dqs_oe}), 32'(0));
    check("mid_rst_err", 32'({err_closed, err_act_open, err_overlap, err_ref_open}), 32'(0));
    check("mid_rst_state", 32'({ref_count, bank_open}), 32'(0));
    RESET_SM_button = 1'b0;
    tick();

    issue(C_ACT, 3'd1, 15'd0);
    check("act1_bank", 32'(bank_open), 32'h02);
    reset_dram_n = 1'b0;
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = C_ACT;
    ba = 3'd0;
    tick();
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    reset_dram_n = 1'b1;
    check("sync_rst_wins", 32'(bank_open), 32'h00);

    issue(C_ACT, 3'd5, 15'd5);
    rd_burst("rd_keep", 3'd5, 15'd0, 64'h0203040506070001);
    issue(C_PRE, 3'd0, 15'h400);
    check("pre_all", 32'(bank_open), 32'h00);

    reset_dram_n = 1'b0;
    tick();
    reset_dram_n = 1'b1;
    repeat (80) tick();
    issue(C_REF, 3'd0, 15'd0);
    check("ref_closed_ok", 32'({err_ref_open, err_tref}), 32'(0));
    repeat (88) tick();
    issue(C_REF, 3'd0, 15'd0);
    check("tref_in_time", 32'(err_tref), 32'(0));
    check("ref_count2", 32'(ref_count), 32'(2));
    repeat (105) tick();
`ifdef DDR3_RESP_REFRESH_CHECK_EN
    check("tref_late", 32'(err_tref), 32'(1));
`else
    check("tref_tied", 32'(err_tref), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
